// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART TX/RX data-path FIFOs.
package uart_fifo_pkg;

   // Read-mode selector values for the FWFT parameter
   localparam int unsigned FIFO_MODE_REG  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   // Default geometry used by the UART TX and RX top levels
   localparam int unsigned UART_FIFO_DATA_W = 8;
   localparam int unsigned UART_FIFO_DEPTH  = 16;

endpackage : uart_fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: register array with synchronous write and asynchronous read.
// Kept apart from the control logic so a RAM macro can replace it later.
module fifo_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned PTR_W      = 4
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [PTR_W-1:0]      i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [PTR_W-1:0]      i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Write port: storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem

// File: rtl/param_sync_fifo.sv
// Parametrised synchronous FIFO: any depth, occupancy count, programmable
// almost flags, registered or first-word-fall-through read, flush, sticky errors.
module param_sync_fifo
   import uart_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_FIFO_DATA_W,
   parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
   parameter int unsigned FWFT       = FIFO_MODE_REG,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2,
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int unsigned PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_ovf_set;
   logic                  w_udf_set;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   // Status decoded straight from the registered count
   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CNT_W'(AF_THRESH));
   assign almost_empty = (r_count <= CNT_W'(AE_THRESH));
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // Flush blocks both ports and suppresses error detection
   assign w_wr_acc  = wr_en && !w_full  && !flush;
   assign w_rd_acc  = rd_en && !w_empty && !flush;
   assign w_ovf_set = wr_en &&  w_full  && !flush;
   assign w_udf_set = rd_en &&  w_empty && !flush;

   // Pointers and occupancy; pointers wrap explicitly for non-power-of-2 depth
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (w_udf_set) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (wr_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_mem_rdata)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented combinationally; rd_en only pops it
      assign rd_data  = w_mem_rdata;
      assign rd_valid = !w_empty;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      // Registered read: data lands one cycle after the accepting edge
      always_ff @(posedge clk) begin
         if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
               r_rd_data <= w_mem_rdata;
            end
         end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
   end

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench: a registered-read FIFO (DEPTH=5) and an FWFT FIFO (DEPTH=4).
module tb_param_sync_fifo;

   logic       clk = 1'b0;
   logic       rst;

   // Registered-read instance (DEPTH=5, AF=3, AE=2)
   logic       a_flush, a_wr_en, a_rd_en, a_clr_err;
   logic [7:0] a_wr_data, a_rd_data;
   logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
   logic [2:0] a_count;

   // FWFT instance (DEPTH=4, AF=2, AE=2)
   logic       b_flush, b_wr_en, b_rd_en, b_clr_err;
   logic [7:0] b_wr_data, b_rd_data;
   logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic [2:0] b_count;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   always #5 clk = ~clk;

   param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
      .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
      .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
      .overflow(a_ovf), .underflow(a_udf), .clr_err(a_clr_err)
   );

   param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
      .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
      .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
      .overflow(b_ovf), .underflow(b_udf), .clr_err(b_clr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops an expected word whenever a DUT presents a read word
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (a_rd_valid === 1'b1) begin
            if (q_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_unexpected_valid got=0x%0h want=no_word", a_rd_data);
            end else begin
               exp = q_a.pop_front();
               chk("a_rd_data", 32'(a_rd_data), 32'(exp));
            end
         end
         if (b_rd_valid === 1'b1 && b_rd_en === 1'b1) begin
            if (q_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected_pop got=0x%0h want=no_word", b_rd_data);
            end else begin
               exp = q_b.pop_front();
               chk("b_rd_data", 32'(b_rd_data), 32'(exp));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_clr_err = 0; a_wr_data = '0;
      b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_clr_err = 0; b_wr_data = '0;
      repeat (2) step();
      rst = 1'b0;

      // Reset state
      chk("rst_count", 32'(a_count), 0);
      chk("rst_empty", 32'(a_empty), 1);
      chk("rst_ae",    32'(a_ae), 1);
      chk("rst_full",  32'(a_full), 0);
      chk("rst_af",    32'(a_af), 0);
      chk("rst_valid", 32'(a_rd_valid), 0);
      chk("rst_data",  32'(a_rd_data), 0);
      chk("rst_ovf",   32'(a_ovf), 0);
      chk("rst_udf",   32'(a_udf), 0);

      // Fill 0x11..0x55, then one write too many
      a_wr_en = 1;
      for (int i = 0; i < 5; i++) begin
         a_wr_data = 8'(17 * (i + 1));
         step();
         chk("fill_count", 32'(a_count), 32'(i + 1));
         chk("fill_af",    32'(a_af), 32'((i + 1) >= 3));
         chk("fill_ae",    32'(a_ae), 32'((i + 1) <= 2));
         chk("fill_full",  32'(a_full), 32'(i == 4));
         chk("fill_ovf",   32'(a_ovf), 0);
      end
      a_wr_data = 8'h66;
      step();
      a_wr_en = 0;
      chk("ovf_set",   32'(a_ovf), 1);
      chk("ovf_count", 32'(a_count), 5);

      // Drain in order, one-cycle latency
      a_rd_en = 1;
      for (int i = 0; i < 5; i++) begin
         q_a.push_back(8'(17 * (i + 1)));
         step();
         chk("drain_count", 32'(a_count), 32'(4 - i));
      end
      a_rd_en = 0;
      step();
      chk("drain_empty", 32'(a_empty), 1);
      chk("drain_valid", 32'(a_rd_valid), 0);

      // Write/read pairs across the pointer wrap
      for (int i = 0; i < 7; i++) begin
         a_wr_en = 1; a_wr_data = 8'(8'hA0 + i);
         step();
         a_wr_en = 0; a_rd_en = 1;
         q_a.push_back(8'(8'hA0 + i));
         step();
         a_rd_en = 0;
         chk("wrap_count", 32'(a_count), 0);
      end
      step();

      // Simultaneous read/write while full
      a_clr_err = 1;
      step();
      a_clr_err = 0;
      chk("clr_ovf", 32'(a_ovf), 0);
      a_wr_en = 1;
      for (int i = 0; i < 5; i++) begin
         a_wr_data = 8'(17 * (i + 1));
         step();
      end
      chk("refill_full", 32'(a_full), 1);
      a_rd_en = 1; a_wr_data = 8'hAA;
      q_a.push_back(8'h11);
      step();
      a_wr_en = 0;
      chk("rw_full_count", 32'(a_count), 4);
      chk("rw_full_ovf",   32'(a_ovf), 1);
      for (int i = 1; i < 5; i++) begin
         q_a.push_back(8'(17 * (i + 1)));
         step();
      end
      a_rd_en = 0;
      step();
      chk("rw_drained", 32'(a_count), 0);

      // Simultaneous read/write while empty: no bypass
      a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h77;
      step();
      a_wr_en = 0; a_rd_en = 0;
      chk("rw_empty_count", 32'(a_count), 1);
      chk("rw_empty_udf",   32'(a_udf), 1);
      chk("rw_empty_valid", 32'(a_rd_valid), 0);

      // Flush beats simultaneous requests
      a_wr_en = 1;
      a_wr_data = 8'h01; step();
      a_wr_data = 8'h02; step();
      a_wr_en = 0;
      chk("pre_flush_count", 32'(a_count), 3);
      a_clr_err = 1; step(); a_clr_err = 0;
      chk("clr_udf", 32'(a_udf), 0);
      a_flush = 1; a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'hEE;
      step();
      a_flush = 0; a_wr_en = 0; a_rd_en = 0;
      chk("flush_count", 32'(a_count), 0);
      chk("flush_empty", 32'(a_empty), 1);
      chk("flush_ovf",   32'(a_ovf), 0);
      chk("flush_udf",   32'(a_udf), 0);
      chk("flush_valid", 32'(a_rd_valid), 0);
      chk("flush_hold",  32'(a_rd_data), 32'h55);

      // Overflow set in the same cycle as clr_err
      a_wr_en = 1;
      for (int i = 0; i < 6; i++) begin
         a_wr_data = 8'(8'h31 + i);
         step();
      end
      chk("ovf2_set", 32'(a_ovf), 1);
      a_clr_err = 1;
      step();
      chk("ovf_set_wins", 32'(a_ovf), 1);
      a_wr_en = 0;
      step();
      a_clr_err = 0;
      chk("ovf_clr_alone", 32'(a_ovf), 0);

      // Reset mid-operation
      a_rd_en = 1;
      q_a.push_back(8'h31);
      step();
      a_rd_en = 0;
      chk("pre_rst_count", 32'(a_count), 4);
      rst = 1; a_wr_en = 1; a_rd_en = 1;
      step();
      rst = 0; a_wr_en = 0; a_rd_en = 0;
      chk("mid_rst_count", 32'(a_count), 0);
      chk("mid_rst_empty", 32'(a_empty), 1);
      chk("mid_rst_data",  32'(a_rd_data), 0);
      chk("mid_rst_valid", 32'(a_rd_valid), 0);
      chk("mid_rst_ovf",   32'(a_ovf), 0);
      chk("mid_rst_udf",   32'(a_udf), 0);

      // FWFT: head word visible without rd_en
      b_wr_en = 1; b_wr_data = 8'h3C;
      step();
      b_wr_en = 0;
      chk("fw_valid", 32'(b_rd_valid), 1);
      chk("fw_data",  32'(b_rd_data), 32'h3C);
      chk("fw_count", 32'(b_count), 1);
      b_rd_en = 1;
      q_b.push_back(8'h3C);
      step();
      b_rd_en = 0;
      chk("fw_pop_empty", 32'(b_empty), 1);
      chk("fw_pop_valid", 32'(b_rd_valid), 0);
      b_wr_en = 1;
      for (int i = 1; i <= 3; i++) begin
         b_wr_data = 8'(i);
         step();
      end
      b_wr_en = 0;
      chk("fw_af",   32'(b_af), 1);
      chk("fw_full", 32'(b_full), 0);
      b_rd_en = 1;
      for (int i = 1; i <= 3; i++) begin
         q_b.push_back(8'(i));
         step();
      end
      b_rd_en = 0;
      step();
      chk("fw_end_empty", 32'(b_empty), 1);

      chk("q_a_drained", 32'(q_a.size()), 0);
      chk("q_b_drained", 32'(q_b.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_param_sync_fifo

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised synchronous FIFO for the UART TX/RX data paths, replacing the fixed 8-bit/256-deep buffer. It adds:
- arbitrary (non-power-of-2) depth with correct wrap;
- a full-range occupancy count;
- programmable almost-full/almost-empty flags;
- a selectable first-word-fall-through read mode;
- synchronous flush;
- sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all stored words
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read (pop) request
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  rd_data holds a valid popped word (FWFT=0) or the head word (FWFT=1)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  CNT_W  occupancy; CNT_W = $clog2(DEPTH+1)
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst sampled on clk rising edge).
- Reset values:
  - wr_ptr = rd_ptr = 0; count = 0.
  - rd_data = 0; rd_valid = 0; overflow = underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Accept rules:
  - write accepted = wr_en && !full && !flush.
  - read accepted = rd_en && !empty && !flush.
- Pointers: PTR_W = max(1, $clog2(DEPTH)). Each pointer increments on accept and wraps from DEPTH-1 to 0 (explicit compare, not natural overflow).
- count:
  - +1 on write only, -1 on read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Simultaneous rd/wr:
  - When full: read accepted, write rejected (overflow set).
  - When empty: write accepted, read rejected (underflow set). No write-to-read bypass.
- Flags are decoded combinationally from the registered count and are valid in the same cycle as count.
- FWFT=0:
  - rd_data is registered, loaded with mem[rd_ptr] on the edge that accepts a read (1-cycle latency).
  - rd_data holds its value otherwise.
  - rd_valid pulses high for exactly the cycle after each accepted read.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en acts as an acknowledge/pop. Zero latency.
- flush:
  - Has priority over wr_en/rd_en; both are ignored that cycle and no error is flagged.
  - Next cycle: pointers = 0, count = 0, rd_valid = 0.
  - rd_data holds its value (FWFT=0).
- Error flags:
  - overflow sets on wr_en && full && !flush; underflow sets on rd_en && empty && !flush.
  - Both remain set until clr_err. Set wins over clr_err in the same cycle.
- rst asserted mid-operation: all state returns to reset values at that edge; in-flight requests are discarded.

Decomposition:
- Shared package uart_fifo_pkg:
  - FIFO_MODE_REG = 0, FIFO_MODE_FWFT = 1 constants.
  - Default DATA_WIDTH/DEPTH constants used by the UART TX and RX top levels.
- One sub-module, fifo_mem:
  - DEPTH x DATA_WIDTH register array with a synchronous write port and asynchronous read port.
  - Keeps the storage separate from pointer/flag control so it can later be swapped for a RAM macro.

Test Plan:
- Reset, then DEPTH=5, FWFT=0: write 0x11..0x55 -> full=1 after 5th edge, count=5, almost_full=1 from count=3; 6th write -> overflow=1, count stays 5.
- Read 5 words (FWFT=0) -> rd_data=0x11..0x55, each one cycle after rd_en, rd_valid 1-cycle pulses; then empty=1. 7 more write/read pairs -> pointer wrap 4->0 with data order preserved.
- Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> read 0x11 accepted, write rejected, count 5->4, overflow=1. Empty FIFO, both high -> count 0->1, no rd_valid, underflow=1.
- FWFT=1: write 0x3C to empty -> next cycle rd_valid=1, rd_data=0x3C with no rd_en. Assert rd_en -> next cycle empty=1, rd_valid=0.
- count=3 with flush=1, wr_en=1, rd_en=1 -> next cycle count=0, empty=1, no error flags. overflow set and clr_err asserted in the same cycle as a new overflow -> overflow stays 1; clr_err alone -> 0.
- rst pulse at count=4 -> next cycle count=0, empty=1, rd_data=0, error flags=0.
